// File: rtl/decode_stage.sv
// Instruction-decode stage: field split, 32x16 GPR file, per-register scoreboard,
// and a registered operand bundle handed to execute over valid/ready.
module decode_stage #(
  parameter int unsigned NUM_GPR = 32,
  parameter int unsigned DATA_W  = 16,
  parameter logic [4:0]  OPC_NOP = 5'b00000,
  parameter logic [4:0]  OPC_MOV = 5'b00001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_ir,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [4:0]        ex_oper_type,
  output logic [4:0]        ex_rdst,
  output logic              ex_imm_mode,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush
);

  logic [DATA_W-1:0]  gpr_q [NUM_GPR];
  logic [NUM_GPR-1:0] pending_q, pending_d;

  logic [4:0]  oper_type, rdst, rsrc1, rsrc2;
  logic        imm_mode;
  logic [15:0] imm;

  assign oper_type = if_ir[31:27];
  assign rdst      = if_ir[26:22];
  assign rsrc1     = if_ir[21:17];
  assign imm_mode  = if_ir[16];
  assign rsrc2     = if_ir[15:11];
  assign imm       = if_ir[15:0];

  logic uses1, uses2, writes;
  logic wb_hit1, wb_hit2, wb_hitd;
  logic hazard, accept;

  assign uses1  = !((oper_type == OPC_MOV) && imm_mode);
  assign uses2  = !imm_mode;
  assign writes = (oper_type != OPC_NOP);

  assign wb_hit1 = wb_en && (wb_addr == rsrc1);
  assign wb_hit2 = wb_en && (wb_addr == rsrc2);
  assign wb_hitd = wb_en && (wb_addr == rdst);

  // A writeback landing this cycle resolves the dependency via the operand bypass.
  assign hazard = (uses1  && pending_q[rsrc1] && !wb_hit1) ||
                  (uses2  && pending_q[rsrc2] && !wb_hit2) ||
                  (writes && pending_q[rdst]  && !wb_hitd);

  assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign accept   = if_valid && if_ready;

  logic [DATA_W-1:0] op1_rd, op2_rd;

  assign op1_rd = wb_hit1 ? wb_data : gpr_q[rsrc1];
  assign op2_rd = imm_mode ? DATA_W'(imm) : (wb_hit2 ? wb_data : gpr_q[rsrc2]);

  // Set is applied last so a same-edge issue keeps ownership of the register.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (flush && ex_valid && (ex_oper_type != OPC_NOP)) begin
      pending_d[ex_rdst] = 1'b0;
    end
    if (accept && writes) begin
      pending_d[rdst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      if (wb_en) begin
        gpr_q[wb_addr] <= wb_data;
      end
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_oper_type <= '0;
      ex_rdst      <= '0;
      ex_imm_mode  <= 1'b0;
      ex_op1       <= '0;
      ex_op2       <= '0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_oper_type <= oper_type;
      ex_rdst      <= rdst;
      ex_imm_mode  <= imm_mode;
      ex_op1       <= op1_rd;
      ex_op2       <= op2_rd;
    end else if (flush || ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
